// File: rtl/wb_resolve_unit_if.sv
// MEM/WB-to-writeback bundle: latch fields in, regfile/redirect/flush/counter results out.
interface wb_resolve_unit_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
);
    logic                 valid;
    logic [3:0]           opcode;
    logic [2:0]           nzp;
    logic                 load_cc;
    logic                 load_reg;
    logic [1:0]           result_sel;
    logic [WIDTH-1:0]     alu_out;
    logic [WIDTH-1:0]     mem_data;
    logic [WIDTH-1:0]     pc_out;
    logic                 clr_counters;
    logic [1:0]           cnt_sel;
    logic [WIDTH-1:0]     regfile_in;
    logic [2:0]           dest;
    logic                 load_regfile;
    logic [2:0]           cc;
    logic                 redirect;
    logic [WIDTH-1:0]     redirect_pc;
    logic                 flush;
    logic [CNT_WIDTH-1:0] cnt_out;

    modport master (
        output valid, opcode, nzp, load_cc, load_reg, result_sel,
               alu_out, mem_data, pc_out, clr_counters, cnt_sel,
        input  regfile_in, dest, load_regfile, cc, redirect, redirect_pc,
               flush, cnt_out
    );

    modport slave (
        input  valid, opcode, nzp, load_cc, load_reg, result_sel,
               alu_out, mem_data, pc_out, clr_counters, cnt_sel,
        output regfile_in, dest, load_regfile, cc, redirect, redirect_pc,
               flush, cnt_out
    );
endinterface

// File: rtl/wb_resolve_unit.sv
// LC-3b writeback stage: result select, CC register, branch resolution against a
// static prediction, multi-cycle flush on redirect, and saturating perf counters.
module wb_resolve_unit #(
    parameter int WIDTH         = 16,
    parameter int CNT_WIDTH     = 16,
    parameter int FLUSH_CYCLES  = 1,
    parameter int PREDICT_TAKEN = 0
) (
    input logic              clk,
    input logic              rst_n,
    wb_resolve_unit_if.slave bus
);
    localparam int   HW = $clog2(FLUSH_CYCLES + 1);
    localparam logic PT = (PREDICT_TAKEN != 0);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t               r_state, w_state_nxt;
    logic [HW-1:0]        r_hold, w_hold_nxt;
    logic [2:0]           r_cc;
    logic [CNT_WIDTH-1:0] r_cnt_br, r_cnt_mis, r_cnt_red;

    logic [WIDTH-1:0] w_wb;
    logic [2:0]       w_gencc;
    logic             w_squash, w_live, w_is_br, w_taken, w_mispredict, w_uncond, w_redirect;

    assign w_squash = (r_state == S_FLUSH);
    assign w_live   = bus.valid & ~w_squash;

    always_comb begin
        w_wb = '0;
        case (bus.result_sel)
            2'd0:    w_wb = bus.alu_out;
            2'd1:    w_wb = bus.mem_data;
            2'd2:    w_wb = bus.pc_out;
            default: w_wb = '0;
        endcase
    end

    assign w_gencc = w_wb[WIDTH-1] ? 3'b100 : ((w_wb == '0) ? 3'b010 : 3'b001);

    // Branch condition uses the CC held before this instruction's own CC update.
    assign w_is_br      = (bus.opcode == 4'b0000) && (bus.nzp != 3'b000);
    assign w_taken      = |(bus.nzp & r_cc);
    assign w_mispredict = w_is_br && (w_taken != PT);
    assign w_uncond     = (bus.opcode == 4'b1100) || (bus.opcode == 4'b0100) ||
                          (bus.opcode == 4'b1111);
    assign w_redirect   = w_live & (w_mispredict | w_uncond);

    assign bus.regfile_in   = w_wb;
    assign bus.dest         = bus.nzp;
    assign bus.load_regfile = w_live & bus.load_reg;
    assign bus.cc           = r_cc;
    assign bus.redirect     = w_redirect;
    assign bus.redirect_pc  = !w_redirect ? '0 :
                              ((w_uncond || w_taken) ? bus.mem_data : bus.pc_out);
    assign bus.flush        = w_redirect | w_squash;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // The redirect cycle itself is the first flush cycle, so FLUSH holds FLUSH_CYCLES-1 more.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            S_IDLE: begin
                if (w_redirect && (FLUSH_CYCLES > 1)) begin
                    w_state_nxt = S_FLUSH;
                    w_hold_nxt  = HW'(FLUSH_CYCLES - 1);
                end
            end
            S_FLUSH: begin
                if (r_hold <= HW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold - HW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cc <= 3'b010;
        end else if (w_live && bus.load_cc) begin
            r_cc <= w_gencc;
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr_counters) begin
            r_cnt_br  <= '0;
            r_cnt_mis <= '0;
            r_cnt_red <= '0;
        end else begin
            if (w_live && w_is_br)      r_cnt_br  <= sat_inc(r_cnt_br);
            if (w_live && w_mispredict) r_cnt_mis <= sat_inc(r_cnt_mis);
            if (w_redirect)             r_cnt_red <= sat_inc(r_cnt_red);
        end
    end

    always_comb begin
        bus.cnt_out = '0;
        case (bus.cnt_sel)
            2'd0:    bus.cnt_out = r_cnt_br;
            2'd1:    bus.cnt_out = r_cnt_mis;
            2'd2:    bus.cnt_out = r_cnt_red;
            default: bus.cnt_out = '0;
        endcase
    end
endmodule

// File: tb/tb_wb_resolve_unit.sv
// Directed bench over four parameterisations of wb_resolve_unit sharing one clock.
`timescale 1ns/1ps
module tb_wb_resolve_unit;
    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [2:0]  nzp;
        logic        load_cc;
        logic        load_reg;
        logic [1:0]  result_sel;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [15:0] pc;
        logic        clr;
        logic [1:0]  cnt_sel;
    } stim_t;

    localparam stim_t IDLE_S = '0;

    logic  clk = 1'b0;
    logic  rst0, rst1, rst2, rst3;
    stim_t s0, s1, s2, s3;
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    wb_resolve_unit_if #(.WIDTH(16), .CNT_WIDTH(16)) if0 ();
    wb_resolve_unit_if #(.WIDTH(16), .CNT_WIDTH(4))  if1 ();
    wb_resolve_unit_if #(.WIDTH(16), .CNT_WIDTH(16)) if2 ();
    wb_resolve_unit_if #(.WIDTH(16), .CNT_WIDTH(16)) if3 ();

`define WB_DRIVE(IFC, S) \
    assign IFC.valid = S.valid; assign IFC.opcode = S.opcode; assign IFC.nzp = S.nzp; \
    assign IFC.load_cc = S.load_cc; assign IFC.load_reg = S.load_reg; \
    assign IFC.result_sel = S.result_sel; assign IFC.alu_out = S.alu; \
    assign IFC.mem_data = S.mem; assign IFC.pc_out = S.pc; \
    assign IFC.clr_counters = S.clr; assign IFC.cnt_sel = S.cnt_sel;

    `WB_DRIVE(if0, s0)
    `WB_DRIVE(if1, s1)
    `WB_DRIVE(if2, s2)
    `WB_DRIVE(if3, s3)

    wb_resolve_unit #(.WIDTH(16), .CNT_WIDTH(16), .FLUSH_CYCLES(1), .PREDICT_TAKEN(0))
        u0 (.clk(clk), .rst_n(rst0), .bus(if0));
    wb_resolve_unit #(.WIDTH(16), .CNT_WIDTH(4), .FLUSH_CYCLES(1), .PREDICT_TAKEN(1))
        u1 (.clk(clk), .rst_n(rst1), .bus(if1));
    wb_resolve_unit #(.WIDTH(16), .CNT_WIDTH(16), .FLUSH_CYCLES(3), .PREDICT_TAKEN(0))
        u2 (.clk(clk), .rst_n(rst2), .bus(if2));
    wb_resolve_unit #(.WIDTH(16), .CNT_WIDTH(16), .FLUSH_CYCLES(4), .PREDICT_TAKEN(0))
        u3 (.clk(clk), .rst_n(rst3), .bus(if3));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge, checks 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        s0 = IDLE_S; s1 = IDLE_S; s2 = IDLE_S; s3 = IDLE_S;
        cyc(); cyc();
        #1;
        check_eq("rst_cc",       32'(if0.cc), 32'h2);
        check_eq("rst_flush",    32'(if0.flush), 32'h0);
        check_eq("rst_redirect", 32'(if0.redirect), 32'h0);
        check_eq("rst_rpc",      32'(if0.redirect_pc), 32'h0);
        check_eq("rst_cnt",      32'(if0.cnt_out), 32'h0);
        check_eq("rst_flush_fc3", 32'(if2.flush), 32'h0);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        cyc();

        // ---- u0: writeback select and CC ----
        s0 = IDLE_S; s0.valid = 1'b1; s0.opcode = 4'b0001; s0.nzp = 3'b011;
        s0.load_cc = 1'b1; s0.load_reg = 1'b1; s0.alu = 16'h8000;
        #1;
        check_eq("wb_alu",   32'(if0.regfile_in), 32'h8000);
        check_eq("wb_load",  32'(if0.load_regfile), 32'h1);
        check_eq("wb_dest",  32'(if0.dest), 32'h3);
        cyc();
        s0.alu = 16'h0000;
        #1;
        check_eq("cc_neg", 32'(if0.cc), 32'h4);
        cyc();
        s0 = IDLE_S; s0.result_sel = 2'd2; s0.pc = 16'h1234; s0.load_reg = 1'b1;
        #1;
        check_eq("cc_zero",     32'(if0.cc), 32'h2);
        check_eq("wb_pc",       32'(if0.regfile_in), 32'h1234);
        check_eq("wb_novalid",  32'(if0.load_regfile), 32'h0);
        s0.result_sel = 2'd1; s0.mem = 16'hBEEF;
        #1;
        check_eq("wb_mem", 32'(if0.regfile_in), 32'hBEEF);
        s0.result_sel = 2'd3;
        #1;
        check_eq("wb_zero", 32'(if0.regfile_in), 32'h0);

        // ---- u0: BRz taken with fall-through prediction ----
        s0 = IDLE_S; s0.valid = 1'b1; s0.opcode = 4'b0000; s0.nzp = 3'b010;
        s0.pc = 16'h3002; s0.mem = 16'h3010;
        #1;
        check_eq("brz_redirect", 32'(if0.redirect), 32'h1);
        check_eq("brz_rpc",      32'(if0.redirect_pc), 32'h3010);
        check_eq("brz_flush",    32'(if0.flush), 32'h1);
        cyc();
        s0.nzp = 3'b100;
        #1;
        check_eq("brn_redirect", 32'(if0.redirect), 32'h0);
        check_eq("brn_rpc",      32'(if0.redirect_pc), 32'h0);
        check_eq("brn_flush",    32'(if0.flush), 32'h0);
        s0.cnt_sel = 2'd1;
        #1;
        check_eq("mis_after_brz", 32'(if0.cnt_out), 32'h1);
        s0.cnt_sel = 2'd0;
        #1;
        check_eq("br_after_brz", 32'(if0.cnt_out), 32'h1);
        cyc();
        s0 = IDLE_S;
        #1;
        check_eq("br_after_brn", 32'(if0.cnt_out), 32'h2);
        s0.cnt_sel = 2'd1;
        #1;
        check_eq("mis_after_brn", 32'(if0.cnt_out), 32'h1);
        s0.cnt_sel = 2'd2;
        #1;
        check_eq("red_after_brn", 32'(if0.cnt_out), 32'h1);
        s0.cnt_sel = 2'd3;
        #1;
        check_eq("cnt_sel3", 32'(if0.cnt_out), 32'h0);

        // ---- u1: taken prediction, NOP branch, saturation, clear ----
        s1 = IDLE_S; s1.valid = 1'b1; s1.opcode = 4'b0000; s1.nzp = 3'b001;
        s1.pc = 16'h4002; s1.mem = 16'h4100;
        #1;
        check_eq("brp_nt_redirect", 32'(if1.redirect), 32'h1);
        check_eq("brp_nt_rpc",      32'(if1.redirect_pc), 32'h4002);
        cyc();
        s1.nzp = 3'b000;
        #1;
        check_eq("nop_redirect", 32'(if1.redirect), 32'h0);
        cyc();
        s1 = IDLE_S;
        #1;
        check_eq("nop_br_cnt", 32'(if1.cnt_out), 32'h1);
        s1.cnt_sel = 2'd1;
        #1;
        check_eq("nop_mis_cnt", 32'(if1.cnt_out), 32'h1);
        s1.clr = 1'b1;
        cyc();
        s1 = IDLE_S; s1.cnt_sel = 2'd2;
        #1;
        check_eq("clr_red_cnt", 32'(if1.cnt_out), 32'h0);
        s1.valid = 1'b1; s1.opcode = 4'b1100; s1.mem = 16'h5000;
        for (int i = 0; i < 16; i++) cyc();
        s1.valid = 1'b0;
        #1;
        check_eq("red_saturate", 32'(if1.cnt_out), 32'hF);
        s1.cnt_sel = 2'd0;
        #1;
        check_eq("br_after_jmps", 32'(if1.cnt_out), 32'h0);
        s1.cnt_sel = 2'd2; s1.valid = 1'b1; s1.clr = 1'b1;
        cyc();
        s1 = IDLE_S; s1.cnt_sel = 2'd2;
        #1;
        check_eq("clr_beats_inc", 32'(if1.cnt_out), 32'h0);

        // ---- u2: 3-cycle flush, inputs ignored while squashing ----
        s2 = IDLE_S; s2.valid = 1'b1; s2.opcode = 4'b1100; s2.mem = 16'h5000;
        #1;
        check_eq("jmp_redirect", 32'(if2.redirect), 32'h1);
        check_eq("jmp_rpc",      32'(if2.redirect_pc), 32'h5000);
        check_eq("jmp_flush_c1", 32'(if2.flush), 32'h1);
        for (int c = 2; c <= 3; c++) begin
            cyc();
            s2 = IDLE_S; s2.valid = 1'b1; s2.opcode = 4'b0100; s2.mem = 16'h6000;
            s2.load_reg = 1'b1; s2.load_cc = 1'b1; s2.alu = 16'h8000;
            #1;
            check_eq($sformatf("sq_flush_c%0d", c),  32'(if2.flush), 32'h1);
            check_eq($sformatf("sq_load_c%0d", c),   32'(if2.load_regfile), 32'h0);
            check_eq($sformatf("sq_redir_c%0d", c),  32'(if2.redirect), 32'h0);
            check_eq($sformatf("sq_rpc_c%0d", c),    32'(if2.redirect_pc), 32'h0);
        end
        cyc();
        s2 = IDLE_S; s2.cnt_sel = 2'd2;
        #1;
        check_eq("jmp_flush_c4", 32'(if2.flush), 32'h0);
        check_eq("sq_red_cnt",   32'(if2.cnt_out), 32'h1);
        check_eq("sq_cc_kept",   32'(if2.cc), 32'h2);

        // ---- u3: reset in the middle of a 4-cycle flush ----
        s3 = IDLE_S; s3.valid = 1'b1; s3.opcode = 4'b0001; s3.load_cc = 1'b1; s3.alu = 16'h0001;
        cyc();
        s3 = IDLE_S; s3.valid = 1'b1; s3.opcode = 4'b1111; s3.mem = 16'h0025;
        #1;
        check_eq("pre_rst_cc", 32'(if3.cc), 32'h1);
        cyc();
        s3 = IDLE_S; s3.cnt_sel = 2'd2;
        #1;
        check_eq("mid_flush",     32'(if3.flush), 32'h1);
        check_eq("pre_rst_red",   32'(if3.cnt_out), 32'h1);
        rst3 = 1'b0;
        cyc();
        rst3 = 1'b1;
        #1;
        check_eq("rst_mid_flush", 32'(if3.flush), 32'h0);
        check_eq("rst_mid_cc",    32'(if3.cc), 32'h2);
        check_eq("rst_mid_red",   32'(if3.cnt_out), 32'h0);
        s3.cnt_sel = 2'd0;
        #1;
        check_eq("rst_mid_br", 32'(if3.cnt_out), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
